// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default field widths, accumulator state encoding
// and a +0 constant helper.
package fp_pkg;

  localparam int FP_EXP_WIDTH      = 8;
  localparam int FP_MANTISSA_WIDTH = 23;
  localparam int FP_MAX_W          = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } facc_state_t;

  // Callers cast the result down to their own word width.
  function automatic logic [FP_MAX_W-1:0] fp_zero();
    return '0;
  endfunction

endpackage

// File: rtl/fp_adder.sv
// Combinational floating-point adder, round-to-nearest-even, with subnormal support.
// overflow_out marks a finite sum rounded to infinity; underflow_out marks a nonzero subnormal result.
module fp_adder
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH      = FP_EXP_WIDTH,
  parameter int MANTISSA_WIDTH = FP_MANTISSA_WIDTH
) (
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] fpa_out,
  output logic                              overflow_out,
  output logic                              underflow_out
);

  localparam int W  = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int SW = MANTISSA_WIDTH + 4;  // hidden bit, mantissa, guard, round, sticky
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;

  logic                      sa, sb;
  logic [EXP_WIDTH-1:0]      ea, eb;
  logic [MANTISSA_WIDTH-1:0] ma, mb;
  logic                      a_nan, b_nan, a_inf, b_inf;

  logic                      big_s, small_s;
  logic [EXP_WIDTH-1:0]      big_e, small_e;
  logic [MANTISSA_WIDTH:0]   big_sig, small_sig;
  logic [2*SW-1:0]           wide;
  logic [SW-1:0]             aligned;
  logic [SW:0]               sum;
  logic [SW-1:0]             norm;
  logic [EXP_WIDTH-1:0]      exp_field;
  logic [W-2:0]              mag;
  logic                      rnd_up, found;
  int                        diff, exp_n, lz, shamt;

  assign {sa, ea, ma} = a_in;
  assign {sb, eb, mb} = b_in;
  assign a_nan = (ea == EXP_MAX) && (ma != '0);
  assign b_nan = (eb == EXP_MAX) && (mb != '0);
  assign a_inf = (ea == EXP_MAX) && (ma == '0);
  assign b_inf = (eb == EXP_MAX) && (mb == '0);

  always_comb begin
    fpa_out       = '0;
    overflow_out  = 1'b0;
    underflow_out = 1'b0;
    found         = 1'b0;
    lz            = 0;
    shamt         = 0;
    exp_field     = '0;
    mag           = '0;
    rnd_up        = 1'b0;
    norm          = '0;

    // Order operands by magnitude so the subtraction below never goes negative.
    if (a_in[W-2:0] >= b_in[W-2:0]) begin
      big_s   = sa;  big_e   = (ea == '0) ? EXP_WIDTH'(1) : ea;  big_sig   = {ea != '0, ma};
      small_s = sb;  small_e = (eb == '0) ? EXP_WIDTH'(1) : eb;  small_sig = {eb != '0, mb};
    end else begin
      big_s   = sb;  big_e   = (eb == '0) ? EXP_WIDTH'(1) : eb;  big_sig   = {eb != '0, mb};
      small_s = sa;  small_e = (ea == '0) ? EXP_WIDTH'(1) : ea;  small_sig = {ea != '0, ma};
    end

    diff    = int'(big_e) - int'(small_e);
    wide    = {small_sig, 3'b000, {SW{1'b0}}} >> ((diff > SW) ? SW : diff);
    aligned = wide[2*SW-1:SW];
    aligned[0] = aligned[0] | (|wide[SW-1:0]);

    if (big_s != small_s) sum = {1'b0, big_sig, 3'b000} - {1'b0, aligned};
    else                  sum = {1'b0, big_sig, 3'b000} + {1'b0, aligned};

    exp_n = int'(big_e);
    if (sum[SW]) begin
      norm  = {sum[SW:2], sum[1] | sum[0]};
      exp_n = exp_n + 1;
    end else begin
      for (int i = SW - 1; i >= 0; i--) begin
        if (!found) begin
          if (sum[i]) found = 1'b1;
          else        lz    = lz + 1;
        end
      end
      // Stop normalising at the minimum exponent; what remains is subnormal.
      shamt = (lz < exp_n - 1) ? lz : exp_n - 1;
      norm  = sum[SW-1:0] << shamt;
      exp_n = exp_n - shamt;
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      fpa_out = {1'b0, EXP_MAX, {MANTISSA_WIDTH{1'b0}}};
      fpa_out[MANTISSA_WIDTH-1] = 1'b1;
    end else if (a_inf || b_inf) begin
      fpa_out = {a_inf ? sa : sb, EXP_MAX, {MANTISSA_WIDTH{1'b0}}};
    end else if (sum == '0) begin
      fpa_out = {sa & sb, {(W-1){1'b0}}};
    end else if (exp_n >= int'(EXP_MAX)) begin
      fpa_out      = {big_s, EXP_MAX, {MANTISSA_WIDTH{1'b0}}};
      overflow_out = 1'b1;
    end else begin
      exp_field = norm[SW-1] ? EXP_WIDTH'(exp_n) : '0;
      rnd_up    = norm[2] & (norm[1] | norm[0] | norm[3]);
      mag       = {exp_field, norm[SW-2:3]} + {{(W-2){1'b0}}, rnd_up};
      fpa_out       = {big_s, mag};
      overflow_out  = (mag[W-2:MANTISSA_WIDTH] == EXP_MAX);
      underflow_out = (mag[W-2:MANTISSA_WIDTH] == '0) && (mag != '0);
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Streaming accumulator: sums length_in operands through fp_adder, one per cycle,
// and pulses done_out once the final sum and sticky flags are in place.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH      = FP_EXP_WIDTH,
  parameter int MANTISSA_WIDTH = FP_MANTISSA_WIDTH,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  logic                              start_in,
  input  logic [COUNT_WIDTH-1:0]            length_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] data_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] sum_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              overflow_out,
  output logic                              underflow_out
);

  localparam int W = 1 + EXP_WIDTH + MANTISSA_WIDTH;

  facc_state_t            state_q, state_d;
  logic [W-1:0]           acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d;
  logic [W-1:0]           fpa_out;
  logic                   fpa_ovf, fpa_unf;

  fp_adder #(
    .EXP_WIDTH      (EXP_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH)
  ) fpa0 (
    .a_in          (acc_q),
    .b_in          (data_in),
    .fpa_out       (fpa_out),
    .overflow_out  (fpa_ovf),
    .underflow_out (fpa_unf)
  );

  // Handshake: a term is consumed on a rising edge where valid_in && ready_out; ready_out
  // is high only in ACCUM and does not depend on valid_in, so sources may hold data freely.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ready_out = 1'b0;
    done_out  = 1'b0;
    busy_out  = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          acc_d = W'(fp_zero());
          ovf_d = 1'b0;
          unf_d = 1'b0;
          if (length_in != '0) begin
            rem_d   = length_in;
            state_d = ACCUM;
          end else begin
            state_d = FINISH;
          end
        end
      end
      ACCUM: begin
        ready_out = 1'b1;
        if (valid_in) begin
          acc_d = fpa_out;
          ovf_d = ovf_q | fpa_ovf;
          unf_d = unf_q | fpa_unf;
          rem_d = rem_q - COUNT_WIDTH'(1);
          if (rem_q == COUNT_WIDTH'(1)) state_d = FINISH;
        end
      end
      FINISH: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign sum_out       = acc_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

endmodule
